// File: rtl/iir_pkg.sv
// -----------------------------------------------------------------------------
// iir_pkg
// Shared widths, FSM state encoding and the 12-bit saturation helper used by
// the time-multiplexed first-order IIR cascade.
// -----------------------------------------------------------------------------
package iir_pkg;

    localparam int DW_IN = 11;  // input sample width
    localparam int DW    = 12;  // stage operand / output width
    localparam int CW    = 12;  // pole coefficient width
    localparam int ACC_W = 26;  // accumulator width
    localparam int SHIFT = 11;  // Q11 scaling of the coefficients

    // Sequencer states
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 26'sd2047;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -26'sd2048;

    // Clamp a wide signed value into [-2048, 2047].
    function automatic logic signed [DW-1:0] sat12(input logic signed [ACC_W-1:0] v);
        logic signed [DW-1:0] r;
        if (v > SAT_MAX) begin
            r = 12'sh7FF;
        end else if (v < SAT_MIN) begin
            r = 12'sh800;
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/iir_cascade_sequencer_mac.sv
// -----------------------------------------------------------------------------
// iir_stage_mac
// Purely combinational shared datapath for one first-order section:
//   acc = ((x + x_prev) <<< 11) + a * y_prev ;  y = reduce12(acc >>> 11)
// Ports:
//   x, x_prev, y_prev : 12-bit signed operands
//   a                 : 12-bit signed pole coefficient (Q11)
//   y                 : 12-bit signed stage output (wrapped or saturated)
// -----------------------------------------------------------------------------
module iir_stage_mac
    import iir_pkg::*;
#(
    parameter int SAT = 0
) (
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] x_prev,
    input  logic signed [DW-1:0] y_prev,
    input  logic signed [CW-1:0] a,
    output logic signed [DW-1:0] y
);

    logic signed [ACC_W-1:0] sum_ext;
    logic signed [ACC_W-1:0] a_ext;
    logic signed [ACC_W-1:0] yp_ext;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        sum_ext = {{(ACC_W-DW){x[DW-1]}}, x} + {{(ACC_W-DW){x_prev[DW-1]}}, x_prev};
        a_ext   = {{(ACC_W-CW){a[CW-1]}}, a};
        yp_ext  = {{(ACC_W-DW){y_prev[DW-1]}}, y_prev};
        // Both products fit comfortably in 26 bits, so truncating the
        // full-width multiply keeps the exact result.
        acc     = (sum_ext <<< SHIFT) + a_ext * yp_ext;
        // Arithmetic shift gives floor division by 2048.
        shifted = acc >>> SHIFT;
    end

    generate
        if (SAT != 0) begin : g_sat
            assign y = sat12(shifted);
        end else begin : g_wrap
            assign y = shifted[DW-1:0];
        end
    endgenerate

endmodule

// File: rtl/iir_cascade_sequencer.sv
// -----------------------------------------------------------------------------
// iir_cascade_sequencer
// Cascade of NSTAGES first-order IIR sections sharing one MAC, evaluated one
// stage per clock. Owns the per-stage history and the pole coefficient file.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   in_valid, Xin, in_ready   : sample input handshake (11-bit signed)
//   out_valid, Yout           : one-cycle result pulse, Yout held between pulses
//   cfg_we, cfg_addr, cfg_data: coefficient write port (IDLE only)
//   cfg_err                   : pulses the cycle after a dropped write
//   clear                     : flush history while IDLE (blocks acceptance)
//   busy                      : high while the cascade is being evaluated
// -----------------------------------------------------------------------------
module iir_cascade_sequencer
    import iir_pkg::*;
#(
    parameter int                   NSTAGES   = 4,
    parameter logic signed [CW-1:0] A_DEFAULT = 12'sd276,
    parameter int                   SAT       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [DW_IN-1:0] Xin,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [DW-1:0]    Yout,
    input  logic                    cfg_we,
    input  logic [2:0]              cfg_addr,
    input  logic signed [CW-1:0]    cfg_data,
    output logic                    cfg_err,
    input  logic                    clear,
    output logic                    busy
);

    localparam logic [2:0] K_LAST = 3'(NSTAGES - 1);

    logic [0:0]           state_q, state_d;
    logic [2:0]           k_q, k_d;
    logic signed [DW-1:0] x_q, x_d;
    logic signed [DW-1:0] yout_q, yout_d;
    logic                 out_valid_q, out_valid_d;
    logic                 cfg_err_q, cfg_err_d;

    logic signed [DW-1:0] x_prev_q [NSTAGES];
    logic signed [DW-1:0] x_prev_d [NSTAGES];
    logic signed [DW-1:0] y_prev_q [NSTAGES];
    logic signed [DW-1:0] y_prev_d [NSTAGES];
    logic signed [CW-1:0] a_q      [NSTAGES];
    logic signed [CW-1:0] a_d      [NSTAGES];

    logic signed [DW-1:0] sel_x_prev, sel_y_prev, mac_y;
    logic signed [CW-1:0] sel_a;
    logic                 is_idle, is_run, accept, clear_hist, cfg_hit, cfg_ok;

    assign is_idle    = (state_q == IDLE);
    assign is_run     = (state_q == RUN);
    // clear takes priority over a sample in the same IDLE cycle
    assign in_ready   = is_idle & ~rst & ~clear;
    assign accept     = in_valid & in_ready;
    assign clear_hist = is_idle & clear;
    assign cfg_ok     = cfg_we & is_idle & cfg_hit;

    // Operand mux for the stage being evaluated, plus config address decode.
    // Compare-based selection keeps index widths independent of NSTAGES.
    always_comb begin
        sel_x_prev = '0;
        sel_y_prev = '0;
        sel_a      = '0;
        cfg_hit    = 1'b0;
        for (int i = 0; i < NSTAGES; i++) begin
            if (k_q == 3'(i)) begin
                sel_x_prev = x_prev_q[i];
                sel_y_prev = y_prev_q[i];
                sel_a      = a_q[i];
            end
            if (cfg_addr == 3'(i)) begin
                cfg_hit = 1'b1;
            end
        end
    end

    iir_stage_mac #(
        .SAT(SAT)
    ) u_mac (
        .x      (x_q),
        .x_prev (sel_x_prev),
        .y_prev (sel_y_prev),
        .a      (sel_a),
        .y      (mac_y)
    );

    // Per-stage next-state for history and coefficients
    generate
        for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage
            logic stage_upd;
            assign stage_upd    = is_run & (k_q == 3'(gi));
            assign x_prev_d[gi] = clear_hist ? '0 : (stage_upd ? x_q   : x_prev_q[gi]);
            assign y_prev_d[gi] = clear_hist ? '0 : (stage_upd ? mac_y : y_prev_q[gi]);
            assign a_d[gi]      = (cfg_ok && (cfg_addr == 3'(gi))) ? cfg_data : a_q[gi];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        x_d         = x_q;
        yout_d      = yout_q;
        out_valid_d = 1'b0;
        cfg_err_d   = cfg_we & ~cfg_ok;
        if (is_idle) begin
            if (accept) begin
                state_d = RUN;
                k_d     = 3'd0;
                x_d     = {Xin[DW_IN-1], Xin};
            end
        end else begin
            // Each stage output is the next stage's input
            x_d = mac_y;
            if (k_q == K_LAST) begin
                yout_d      = mac_y;
                out_valid_d = 1'b1;
                state_d     = IDLE;
                k_d         = 3'd0;
            end else begin
                k_d = k_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= 3'd0;
            x_q         <= '0;
            yout_q      <= '0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            for (int i = 0; i < NSTAGES; i++) begin
                x_prev_q[i] <= '0;
                y_prev_q[i] <= '0;
                a_q[i]      <= A_DEFAULT;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            x_q         <= x_d;
            yout_q      <= yout_d;
            out_valid_q <= out_valid_d;
            cfg_err_q   <= cfg_err_d;
            for (int i = 0; i < NSTAGES; i++) begin
                x_prev_q[i] <= x_prev_d[i];
                y_prev_q[i] <= y_prev_d[i];
                a_q[i]      <= a_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Yout      = yout_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = is_run;

endmodule
